framebuffer_scheduler: RTL



---
 rtl/framebuffer_pkg.sv | 19 +
 rtl/framebuffer_scheduler_fetch_tracker.sv | 92 +++++++++
 rtl/framebuffer_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the framebuffer scheduler and its fetch tracker.
package framebuffer_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DATA = 2'd2,
        WR_REQ  = 2'd3
    } state_e;

    function automatic int bursts_per_line(input int hor, input int burst);
        return hor / burst;
    endfunction

    localparam int BURSTS_PER_LINE = bursts_per_line(1280, 32);

endpackage

// File: rtl/framebuffer_scheduler_fetch_tracker.sv
// Tracks the line being prefetched: target line, burst index, line base address,
// completion, and the sticky underrun raised by a request that lands on an unfinished fetch.
module fetch_tracker
    import framebuffer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 1280,
    parameter int VER_ACTIVE_PIXELS = 720,
    parameter int BURST_PIXELS      = 32,
    parameter int ADDR_WIDTH        = 24,
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int BW                = $clog2(bursts_per_line(HOR_ACTIVE_PIXELS, BURST_PIXELS) + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_start_i,
    input  logic                  line_start_i,
    input  logic [Y_WIDTH-1:0]    line_y_i,
    input  logic                  in_burst_i,
    input  logic                  burst_done_i,
    output logic                  req_o,
    output logic                  pending_o,
    output logic                  bank_o,
    output logic                  underrun_o,
    output logic [BW-1:0]         burst_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    localparam int BURSTS = bursts_per_line(HOR_ACTIVE_PIXELS, BURST_PIXELS);
    localparam int LOG_B  = $clog2(BURST_PIXELS);

    logic [Y_WIDTH-1:0]    line_q, line_d, req_line;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  pending_q, pending_d;
    logic                  stale_q, stale_d;
    logic                  underrun_q, underrun_d;

    always_comb begin
        req_o    = frame_start_i || (line_start_i && (line_y_i < Y_WIDTH'(VER_ACTIVE_PIXELS - 1)));
        req_line = frame_start_i ? '0 : line_y_i + 1'b1;
    end

    // A burst already launched when a new request arrives belongs to the old line:
    // it is allowed to finish, but its completion must not advance the new line.
    always_comb begin
        line_d     = line_q;
        base_d     = base_q;
        burst_d    = burst_q;
        pending_d  = pending_q;
        stale_d    = stale_q;
        underrun_d = underrun_q;
        if (req_o) begin
            line_d     = req_line;
            base_d     = ADDR_WIDTH'(req_line) * ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
            burst_d    = '0;
            pending_d  = 1'b1;
            stale_d    = in_burst_i && !burst_done_i;
            underrun_d = underrun_q | pending_q;
        end else if (burst_done_i) begin
            stale_d = 1'b0;
            if (!stale_q) begin
                burst_d = burst_q + 1'b1;
                if (burst_q == BW'(BURSTS - 1))
                    pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q     <= '0;
            base_q     <= '0;
            burst_q    <= '0;
            pending_q  <= 1'b0;
            stale_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            line_q     <= line_d;
            base_q     <= base_d;
            burst_q    <= burst_d;
            pending_q  <= pending_d;
            stale_q    <= stale_d;
            underrun_q <= underrun_d;
        end
    end

    assign pending_o  = pending_q;
    assign bank_o     = line_q[0];
    assign underrun_o = underrun_q;
    assign burst_o    = burst_q;
    assign addr_o     = base_q + (ADDR_WIDTH'(burst_q) << LOG_B);

endmodule

// File: rtl/framebuffer_scheduler.sv
// Memory-port sequencer: prefetches the next display line in bursts into the
// ping-pong line buffer and slots game-logic pixel writes between bursts.
module framebuffer_scheduler
    import framebuffer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 1280,
    parameter int VER_ACTIVE_PIXELS = 720,
    parameter int BURST_PIXELS      = 32,
    parameter int ADDR_WIDTH        = 24,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                  clk_rgb,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic [Y_WIDTH-1:0]    line_y,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [23:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic                  rd_valid,
    input  logic [23:0]           rd_data,
    output logic                  lb_we,
    output logic                  lb_bank,
    output logic [X_WIDTH-1:0]    lb_addr,
    output logic [23:0]           lb_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [23:0]           wr_data,
    output logic                  wr_ack,
    output logic                  busy,
    output logic                  underrun
);
    localparam int BW    = $clog2(bursts_per_line(HOR_ACTIVE_PIXELS, BURST_PIXELS) + 1);
    localparam int LOG_B = $clog2(BURST_PIXELS);

    state_e                state_q, state_d;
    logic                  fair_q, fair_d;
    logic [LOG_B-1:0]      beat_q, beat_d;
    logic [X_WIDTH-1:0]    lbase_q, lbase_d;
    logic                  mem_req_q, mem_req_d, mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    pixel_t                mem_wdata_q, mem_wdata_d, lb_data_q, lb_data_d;
    logic                  lb_we_q, lb_we_d, lb_bank_q, lb_bank_d, wr_ack_q, wr_ack_d;
    logic [X_WIDTH-1:0]    lb_addr_q, lb_addr_d;

    logic                  trk_req, trk_pending, trk_bank, trk_underrun;
    logic [BW-1:0]         trk_burst;
    logic [ADDR_WIDTH-1:0] trk_addr;
    logic                  burst_done, in_burst, wr_ok, fetch_go;

    fetch_tracker #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .BURST_PIXELS      (BURST_PIXELS),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .Y_WIDTH           (Y_WIDTH),
        .BW                (BW)
    ) u_tracker (
        .clk_i         (clk_rgb),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .line_start_i  (line_start),
        .line_y_i      (line_y),
        .in_burst_i    (in_burst),
        .burst_done_i  (burst_done),
        .req_o         (trk_req),
        .pending_o     (trk_pending),
        .bank_o        (trk_bank),
        .underrun_o    (trk_underrun),
        .burst_o       (trk_burst),
        .addr_o        (trk_addr)
    );

    assign in_burst = (state_q == RD_REQ) || (state_q == RD_DATA);
    assign wr_ok    = wr_req && !wr_ack_q;
    // Launch is held off in a request cycle so a burst never starts from a stale target.
    assign fetch_go = trk_pending && !trk_req && !(fair_q && wr_ok);

    always_comb begin
        state_d     = state_q;
        fair_d      = fair_q;
        beat_d      = beat_q;
        lbase_d     = lbase_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lb_bank_d   = lb_bank_q;
        lb_addr_d   = lb_addr_q;
        lb_data_d   = lb_data_q;
        lb_we_d     = 1'b0;
        wr_ack_d    = 1'b0;
        burst_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_go) begin
                    state_d     = RD_REQ;
                    mem_write_d = 1'b0;
                    mem_addr_d  = trk_addr;
                    lb_bank_d   = trk_bank;
                    lbase_d     = X_WIDTH'(trk_burst) << LOG_B;
                end else if (wr_ok) begin
                    state_d     = WR_REQ;
                    mem_write_d = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                    fair_d      = 1'b0;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
            end
            RD_DATA: begin
                if (rd_valid) begin
                    lb_we_d   = 1'b1;
                    lb_addr_d = lbase_q + X_WIDTH'(beat_q);
                    lb_data_d = rd_data;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        burst_done = 1'b1;
                        state_d    = IDLE;
                        if (wr_req)
                            fair_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    wr_ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fair_q      <= 1'b0;
            beat_q      <= '0;
            lbase_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lb_we_q     <= 1'b0;
            lb_bank_q   <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fair_q      <= fair_d;
            beat_q      <= beat_d;
            lbase_q     <= lbase_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lb_we_q     <= lb_we_d;
            lb_bank_q   <= lb_bank_d;
            lb_addr_q   <= lb_addr_d;
            lb_data_q   <= lb_data_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign lb_we     = lb_we_q;
    assign lb_bank   = lb_bank_q;
    assign lb_addr   = lb_addr_q;
    assign lb_data   = lb_data_q;
    assign wr_ack    = wr_ack_q;
    assign busy      = trk_pending;
    assign underrun  = trk_underrun;

endmodule
